// File: rtl/sram_arb_pkg.sv
// Shared widths, lane size and FSM states for the 1W1R SRAM arbiter.
// Optional feature macro: SRAM_ARB_BYPASS_EN.
package sram_arb_pkg;

    localparam int NUM_REQ_D    = 4;
    localparam int ADDR_W_D     = 7;
    localparam int DATA_W_D     = 56;
    localparam int NUM_WMASKS_D = 4;
    localparam int LANE_W_D     = DATA_W_D / NUM_WMASKS_D;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_1w1r_arbiter_if.sv
// Client handshakes plus macro pins for the 1W1R SRAM arbiter.
// Optional feature macro: SRAM_ARB_BYPASS_EN (no effect on this file).
interface sram_1w1r_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_D,
    parameter int ADDR_WIDTH = ADDR_W_D,
    parameter int DATA_WIDTH = DATA_W_D,
    parameter int NUM_WMASKS = NUM_WMASKS_D
) ();

    logic [NUM_REQ-1:0]            wr_valid;
    logic [NUM_REQ-1:0]            wr_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
    logic [NUM_REQ*NUM_WMASKS-1:0] wr_mask;

    logic                          rd_valid;
    logic                          rd_ready;
    logic [ADDR_WIDTH-1:0]         rd_addr;
    logic                          rd_rvalid;
    logic [DATA_WIDTH-1:0]         rd_rdata;
    logic                          init_done;

    logic                          sram_csb0;
    logic [NUM_WMASKS-1:0]         sram_wmask0;
    logic [ADDR_WIDTH-1:0]         sram_addr0;
    logic [DATA_WIDTH-1:0]         sram_din0;
    logic                          sram_csb1;
    logic [ADDR_WIDTH-1:0]         sram_addr1;
    logic [DATA_WIDTH-1:0]         sram_dout1;

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_mask,
        input  rd_valid, rd_addr, sram_dout1,
        output wr_ready, rd_ready, rd_rvalid, rd_rdata, init_done,
        output sram_csb0, sram_wmask0, sram_addr0, sram_din0,
        output sram_csb1, sram_addr1
    );

    modport master (
        output wr_valid, wr_addr, wr_data, wr_mask,
        output rd_valid, rd_addr, sram_dout1,
        input  wr_ready, rd_ready, rd_rvalid, rd_rdata, init_done,
        input  sram_csb0, sram_wmask0, sram_addr0, sram_din0,
        input  sram_csb1, sram_addr1
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first request at or after the pointer.
// Pointer moves past the winner only when the caller commits the grant.
module rr_arbiter #(
    parameter int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [PW-1:0] ptr_q;

    always_comb begin
        int k;
        k       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_q) + i) % N;
            if (!gnt_any && req[k]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(k);
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (adv && gnt_any) begin
            ptr_q <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sram_1w1r_arbiter.sv
// Write-port round-robin, read-port pass-through and post-reset zero fill.
// Optional feature macro: SRAM_ARB_BYPASS_EN (same-address read/write bypass).
module sram_1w1r_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_D,
    parameter int ADDR_WIDTH = ADDR_W_D,
    parameter int DATA_WIDTH = DATA_W_D,
    parameter int NUM_WMASKS = NUM_WMASKS_D
) (
    input logic                clk,
    input logic                rst_n,
    sram_1w1r_arbiter_if.slave bus
);

    localparam int LANE_W = DATA_WIDTH / NUM_WMASKS;
    localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    in_init, in_run;
    logic [NUM_REQ-1:0]      cand;
    logic [PW-1:0]           win;
    logic                    win_any;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_data;
    logic [NUM_WMASKS-1:0]   win_mask;
    logic                    rd_go, wr_go, clash;
    logic                    rd_pend_q;
    logic [DATA_WIDTH-1:0]   merged;

    // Zero-fill pins stay quiet while rst_n is held low.
    assign in_init = rst_n && (state_q == ST_INIT);
    assign in_run  = (state_q == ST_RUN);

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.wr_valid),
        .adv     (wr_go),
        .gnt     (cand),
        .gnt_idx (win),
        .gnt_any (win_any)
    );

    assign win_addr = bus.wr_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_data = bus.wr_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    assign win_mask = bus.wr_mask[int'(win)*NUM_WMASKS +: NUM_WMASKS];

    assign rd_go = in_run && bus.rd_valid;
    assign clash = rd_go && win_any && (win_addr == bus.rd_addr);

`ifdef SRAM_ARB_BYPASS_EN
    assign wr_go = in_run && win_any;
`else
    assign wr_go = in_run && win_any && !clash;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = ST_RUN;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        bus.wr_ready    = '0;
        bus.rd_ready    = 1'b0;
        bus.sram_csb0   = 1'b1;
        bus.sram_wmask0 = '0;
        bus.sram_addr0  = '0;
        bus.sram_din0   = '0;
        bus.sram_csb1   = 1'b1;
        bus.sram_addr1  = '0;
        if (in_init) begin
            bus.sram_csb0   = 1'b0;
            bus.sram_wmask0 = '1;
            bus.sram_addr0  = cnt_q;
        end
        if (wr_go) begin
            bus.wr_ready    = cand;
            bus.sram_csb0   = 1'b0;
            bus.sram_wmask0 = win_mask;
            bus.sram_addr0  = win_addr;
            bus.sram_din0   = win_data;
        end
        if (rd_go) begin
            bus.rd_ready   = 1'b1;
            bus.sram_csb1  = 1'b0;
            bus.sram_addr1 = bus.rd_addr;
        end
    end

`ifdef SRAM_ARB_BYPASS_EN
    logic [NUM_WMASKS-1:0] byp_mask_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic [DATA_WIDTH-1:0] byp_bits;

    // Same-address write lanes override the pre-write macro output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_mask_q <= '0;
            byp_data_q <= '0;
        end else begin
            byp_mask_q <= clash ? win_mask : '0;
            if (clash) byp_data_q <= win_data;
        end
    end

    always_comb begin
        byp_bits = '0;
        for (int l = 0; l < NUM_WMASKS; l++) begin
            byp_bits[l*LANE_W +: LANE_W] = {LANE_W{byp_mask_q[l]}};
        end
    end

    assign merged = (bus.sram_dout1 & ~byp_bits) | (byp_data_q & byp_bits);
`else
    assign merged = bus.sram_dout1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            rd_pend_q     <= 1'b0;
            bus.rd_rvalid <= 1'b0;
            bus.rd_rdata  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_pend_q     <= rd_go;
            bus.rd_rvalid <= rd_pend_q;
            if (rd_pend_q) bus.rd_rdata <= merged;
        end
    end

    assign bus.init_done = in_run;

endmodule
